// File: rtl/rr_arb_pkg.sv
// Shared sizes, the select type and the pointer-advance helper for the
// four-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int W     = 4;

  typedef logic [1:0] sel_t;

  // Advance the priority pointer by one, wrapping 3 back to 0.
  function automatic sel_t next_ptr(input sel_t p);
    return sel_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter_4_1_mux_4_1.sv
// Plain combinational 4:1 word select driven by the arbiter's grant index.
module mux_4_1
  import rr_arb_pkg::*;
(
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  sel_t         sel,
  output logic [W-1:0] y
);

  // Route the selected source word to the output.
  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_4_1.sv
// Four-requester round-robin arbiter. Picks one requesting source per cycle
// starting from a rotating priority pointer, drives the mux select, and
// captures the chosen word in a one-entry output register with valid/ready.
module rr_arbiter_4_1
  import rr_arb_pkg::*;
#(
  parameter sel_t START_PTR = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] in_valid,
  output logic [N_REQ-1:0] in_ready,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic [W-1:0]     d2,
  input  logic [W-1:0]     d3,
  output sel_t             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output sel_t             out_src
);

  sel_t         ptr_q, ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  sel_t         out_src_q, out_src_d;

  sel_t         grant_c;
  sel_t         cand_c;
  logic         found_c;
  logic         can_load;
  logic [W-1:0] mux_word;

  // The output slot can take a new word when empty or being drained now.
  assign can_load = !out_valid_q || out_ready;

  // Priority search from the pointer; falls back to the pointer when idle.
  always_comb begin
    grant_c = ptr_q;
    cand_c  = ptr_q;
    found_c = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_c = sel_t'(ptr_q + sel_t'(k));
      if (!found_c && in_valid[cand_c]) begin
        grant_c = cand_c;
        found_c = 1'b1;
      end
    end
  end

  assign sel = grant_c;

  // Only the granted, requesting source sees ready, and never during reset.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign in_ready[gi] = rst && can_load && in_valid[grant_c] &&
                          (grant_c == sel_t'(gi));
  end

  mux_4_1 u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (grant_c),
    .y   (mux_word)
  );

  // Load, drain or hold the output register and advance the pointer on a grant.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (can_load) begin
      if (|in_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_word;
        out_src_d   = grant_c;
        ptr_d       = next_ptr(grant_c);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset drops any held word and restores the start pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q       <= START_PTR;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arbiter_4_1.sv
// Directed bench for rr_arbiter_4_1. Stimulus drives inputs just after the
// rising edge and checks combinational grant outputs mid-cycle; every word
// expected to leave the arbiter is pushed into a queue and a separate monitor
// pops and compares it whenever a word is handed downstream.
module tb_rr_arbiter_4_1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_valid = 4'b0000;
  logic [3:0] in_ready;
  logic [3:0] d0 = 4'hA, d1 = 4'hB, d2 = 4'hC, d3 = 4'hD;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [1:0] out_src;

  int n_vec = 0;
  int n_err = 0;
  logic [5:0] exp_q[$];   // {src, data}
  bit done = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_4_1 #(.START_PTR(2'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One cycle: drive after the edge, return at the following falling edge.
  task automatic cyc(input logic r, input logic [3:0] v, input logic rdy);
    @(posedge clk);
    #2;
    rst       = r;
    in_valid  = v;
    out_ready = rdy;
    @(negedge clk);
  endtask

  // Check grant, ready and output-valid; queue the word expected to load.
  task automatic grant(input string name, input logic [1:0] exp_sel,
                       input logic [3:0] exp_rdy, input logic exp_ov,
                       input logic push, input logic [3:0] exp_word);
    chk({name, " sel"}, int'(sel), int'(exp_sel));
    chk({name, " in_ready"}, int'(in_ready), int'(exp_rdy));
    chk({name, " out_valid"}, int'(out_valid), int'(exp_ov));
    if (push) exp_q.push_back({exp_sel, exp_word});
  endtask

  // Monitor: a word is handed off at the next edge when valid && ready.
  always @(negedge clk) begin
    if (!done && rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected word: got src %0d data %0h, expected none",
                 out_src, out_data);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("mon out_src", int'(out_src), int'(e[5:4]));
        chk("mon out_data", int'(out_data), int'(e[3:0]));
      end
    end
  end

  initial begin
    // 1. Reset held with all sources requesting.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b1111, 1'b1);
      grant("rst", 2'd0, 4'b0000, 1'b0, 1'b0, 4'h0);
    end
    cyc(1'b1, 4'b1111, 1'b1);
    grant("first", 2'd0, 4'b0001, 1'b0, 1'b1, 4'hA);

    // 2. Full rotation at full throughput.
    cyc(1'b1, 4'b1111, 1'b1); grant("rot1", 2'd1, 4'b0010, 1'b1, 1'b1, 4'hB);
    cyc(1'b1, 4'b1111, 1'b1); grant("rot2", 2'd2, 4'b0100, 1'b1, 1'b1, 4'hC);
    cyc(1'b1, 4'b1111, 1'b1); grant("rot3", 2'd3, 4'b1000, 1'b1, 1'b1, 4'hD);
    cyc(1'b1, 4'b1111, 1'b1); grant("rot0", 2'd0, 4'b0001, 1'b1, 1'b1, 4'hA);

    // 3. Single persistent requester.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'b0100, 1'b1);
      grant("solo2", 2'd2, 4'b0100, 1'b1, 1'b1, 4'hC);
    end

    // 4. Downstream stall: word and pointer frozen, no ready upstream.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'b1111, 1'b0);
      grant("stall", 2'd3, 4'b0000, 1'b1, 1'b0, 4'h0);
      chk("stall out_data", int'(out_data), 4'hC);
      chk("stall out_src", int'(out_src), 2);
    end
    cyc(1'b1, 4'b1111, 1'b1);
    grant("unstall", 2'd3, 4'b1000, 1'b1, 1'b1, 4'hD);

    // 5. Wrap from pointer 3, then a late requester on 1.
    cyc(1'b1, 4'b0100, 1'b1); grant("to3", 2'd2, 4'b0100, 1'b1, 1'b1, 4'hC);
    cyc(1'b1, 4'b1001, 1'b1); grant("wrap3", 2'd3, 4'b1000, 1'b1, 1'b1, 4'hD);
    cyc(1'b1, 4'b1001, 1'b1); grant("wrap0", 2'd0, 4'b0001, 1'b1, 1'b1, 4'hA);
    cyc(1'b1, 4'b1011, 1'b1); grant("late1", 2'd1, 4'b0010, 1'b1, 1'b1, 4'hB);
    cyc(1'b1, 4'b0000, 1'b1); grant("idle", 2'd2, 4'b0000, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, 4'b0000, 1'b1); grant("empty", 2'd2, 4'b0000, 1'b0, 1'b0, 4'h0);

    // 6. Reset while a word is stalled: the word must vanish.
    cyc(1'b1, 4'b0010, 1'b1); grant("preload", 2'd1, 4'b0010, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 4'b0000, 1'b0); grant("held", 2'd2, 4'b0000, 1'b1, 1'b0, 4'h0);
    cyc(1'b0, 4'b0000, 1'b0); grant("rstpulse", 2'd2, 4'b0000, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, 4'b0000, 1'b1); grant("postrst", 2'd0, 4'b0000, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 4'b1111, 1'b1); grant("restart", 2'd0, 4'b0001, 1'b0, 1'b1, 4'hA);
    cyc(1'b1, 4'b0000, 1'b1); grant("drain", 2'd1, 4'b0000, 1'b1, 1'b0, 4'h0);
    cyc(1'b1, 4'b0000, 1'b1); grant("drained", 2'd1, 4'b0000, 1'b0, 1'b0, 4'h0);

    chk("queue empty", exp_q.size(), 0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
